// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: forwards ALU results or cache read data to the register file
// and stalls upstream while a load waits on the cache. Define MEM_WB_STALL_CNT_EN to build the stall counter.
module mem_wb_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        RegWrite_i,
  input  logic        MemRead_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [31:0] ALUres_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ready_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rdaddr_q, rdaddr_d;
  logic [31:0] rddata_q, rddata_d;
  logic        lat_regwrite_q, lat_regwrite_d;
  logic [4:0]  lat_rdaddr_q, lat_rdaddr_d;
  logic        load_miss_s;
  logic        stall_s;

  assign load_miss_s = valid_i & MemRead_i & ~mem_ready_i;

  // Stall is combinational so upstream freezes in the same cycle the miss is seen
  always_comb begin
    stall_s = 1'b0;
    case (state_q)
      ST_IDLE: stall_s = load_miss_s;
      ST_WAIT: stall_s = ~mem_ready_i;
      default: stall_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_miss_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Writeback datapath; a write to x0 still updates address/data but never strobes
  always_comb begin
    regwrite_d     = 1'b0;
    rdaddr_d       = rdaddr_q;
    rddata_d       = rddata_q;
    lat_regwrite_d = lat_regwrite_q;
    lat_rdaddr_d   = lat_rdaddr_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (!MemRead_i) begin
            regwrite_d = RegWrite_i & (RDaddr_i != 5'd0);
            rdaddr_d   = RDaddr_i;
            rddata_d   = ALUres_i;
          end else if (mem_ready_i) begin
            regwrite_d = RegWrite_i & (RDaddr_i != 5'd0);
            rdaddr_d   = RDaddr_i;
            rddata_d   = mem_data_i;
          end else begin
            lat_regwrite_d = RegWrite_i;
            lat_rdaddr_d   = RDaddr_i;
          end
        end else begin
          regwrite_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (mem_ready_i) begin
          regwrite_d = lat_regwrite_q & (lat_rdaddr_q != 5'd0);
          rdaddr_d   = lat_rdaddr_q;
          rddata_d   = mem_data_i;
        end else begin
          regwrite_d = 1'b0;
        end
      end
      default: begin
        regwrite_d = 1'b0;
      end
    endcase
  end

  // Output and latched-field registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regwrite_q     <= 1'b0;
      rdaddr_q       <= 5'd0;
      rddata_q       <= 32'd0;
      lat_regwrite_q <= 1'b0;
      lat_rdaddr_q   <= 5'd0;
    end else begin
      regwrite_q     <= regwrite_d;
      rdaddr_q       <= rdaddr_d;
      rddata_q       <= rddata_d;
      lat_regwrite_q <= lat_regwrite_d;
      lat_rdaddr_q   <= lat_rdaddr_d;
    end
  end

`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating stall-cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

  assign stall_o    = stall_s;
  assign RegWrite_o = regwrite_q;
  assign RDaddr_o   = rdaddr_q;
  assign RDdata_o   = rddata_q;

endmodule
